// File: rtl/ipl_decoder_pkg.sv
// Shared state encoding, vector constants and helpers for the IPL decoder.
// Optional macro honoured by ipl_decoder: IACK_TIMEOUT_EN.
package ipl_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        DONE = 2'd2
    } iack_state_t;

    localparam logic [7:0] AUTOVECTOR_BASE = 8'd24;
    localparam logic [7:0] SPURIOUS_VECTOR = 8'd24;
    localparam logic [2:0] LEVEL_NMI       = 3'd7;
    localparam logic [2:0] IPL_IDLE_N      = 3'b111;

    function automatic logic [7:0] autovector(input logic [2:0] lvl);
        return AUTOVECTOR_BASE + {5'b0, lvl};
    endfunction

endpackage

// File: rtl/ipl_decoder_if.sv
// Sequencer handshake and interrupt-acknowledge bus between ipl_decoder (slave)
// and the exception sequencer / bus unit (master).
interface ipl_decoder_if;
    logic       int_pending;
    logic [2:0] int_level;
    logic       iack_start;
    logic       iack_req;
    logic [2:0] iack_lvl;
    logic       dtack_n;
    logic       vpa_n;
    logic       berr_n;
    logic [7:0] data_in;
    logic [7:0] vector;
    logic       vector_valid;
    logic       spurious;

    modport slave (
        input  iack_start, dtack_n, vpa_n, berr_n, data_in,
        output int_pending, int_level, iack_req, iack_lvl, vector, vector_valid, spurious
    );

    modport master (
        output iack_start, dtack_n, vpa_n, berr_n, data_in,
        input  int_pending, int_level, iack_req, iack_lvl, vector, vector_valid, spurious
    );
endinterface

// File: rtl/ipl_decoder_synchronizer.sv
// ipl_synchronizer: SYNC_STAGES-deep synchronizer for ipl_n followed by a
// two-sample stability filter; outputs the filtered active-high level.
module ipl_synchronizer
    import ipl_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] ipl_n,
    output logic [2:0] level
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("SYNC_STAGES must be at least 2");
    end

    logic [2:0] chain [SYNC_STAGES];
    logic [2:0] prev_sample;
    logic [2:0] held;
    logic       stable;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                chain[i] <= IPL_IDLE_N;
            end
            prev_sample <= IPL_IDLE_N;
            held        <= '0;
        end else begin
            chain[0] <= ipl_n;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev_sample <= chain[SYNC_STAGES-1];
            if (stable) begin
                held <= ~chain[SYNC_STAGES-1];
            end
        end
    end

    // Bypass the hold register when stable so the level appears SYNC_STAGES+1 cycles after the pin.
    assign stable = (chain[SYNC_STAGES-1] == prev_sample);
    assign level  = stable ? ~chain[SYNC_STAGES-1] : held;

endmodule

// File: rtl/ipl_decoder.sv
// CPU-side IPL receiver: mask compare, level-7 edge latch and acknowledge FSM.
// Optional macro: IACK_TIMEOUT_EN bounds the acknowledge cycle with a spurious timeout.
module ipl_decoder
    import ipl_decoder_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ipl_n,
    input  logic [2:0]        imask,
    ipl_decoder_if.slave      bus
);

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    iack_state_t state_q, state_d;
    logic [2:0]  level;
    logic [2:0]  prev_level;
    logic        nmi_latch;
    logic        normal_pend;
    logic        pending;
    logic        accept;
    logic        term;
    logic [7:0]  term_vec;
    logic        term_spur;
    logic [2:0]  iack_lvl_q;
    logic [7:0]  vector_q;
    logic        spurious_q;
    logic        timeout_hit;

    ipl_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .ipl_n (ipl_n),
        .level (level)
    );

    // Level 7 is excluded from the mask compare; it only pends through the edge latch.
    assign normal_pend = (level != LEVEL_NMI) && (level > imask);
    assign pending     = normal_pend || nmi_latch;

`ifdef IACK_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] ack_cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_cycles <= '0;
        end else if (accept) begin
            ack_cycles <= '0;
        end else if (state_q == ACK) begin
            ack_cycles <= ack_cycles + 1'b1;
        end
    end

    assign timeout_hit = (ack_cycles == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        term      = 1'b0;
        term_vec  = vector_q;
        term_spur = spurious_q;
        case (state_q)
            IDLE: begin
                if (bus.iack_start && pending) begin
                    accept  = 1'b1;
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!bus.berr_n) begin
                    term      = 1'b1;
                    term_vec  = SPURIOUS_VECTOR;
                    term_spur = 1'b1;
                end else if (!bus.vpa_n) begin
                    term      = 1'b1;
                    term_vec  = autovector(iack_lvl_q);
                    term_spur = 1'b0;
                end else if (!bus.dtack_n) begin
                    term      = 1'b1;
                    term_vec  = bus.data_in;
                    term_spur = 1'b0;
                end else if (timeout_hit) begin
                    term      = 1'b1;
                    term_vec  = SPURIOUS_VECTOR;
                    term_spur = 1'b1;
                end
                if (term) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            prev_level <= '0;
            nmi_latch  <= 1'b0;
            iack_lvl_q <= '0;
            vector_q   <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_level <= level;
            // Accepting the NMI wins over a coincident edge: that edge is the one being serviced.
            if (accept && (level == LEVEL_NMI)) begin
                nmi_latch <= 1'b0;
            end else if ((level == LEVEL_NMI) && (prev_level != LEVEL_NMI)) begin
                nmi_latch <= 1'b1;
            end
            if (accept) begin
                iack_lvl_q <= level;
            end
            if (term) begin
                vector_q   <= term_vec;
                spurious_q <= term_spur;
            end
        end
    end

    assign bus.int_pending  = (state_q == IDLE) && pending;
    assign bus.int_level    = (state_q == IDLE) ? level : iack_lvl_q;
    assign bus.iack_req     = (state_q == ACK);
    assign bus.iack_lvl     = iack_lvl_q;
    assign bus.vector       = vector_q;
    assign bus.vector_valid = (state_q == DONE);
    assign bus.spurious     = spurious_q;

endmodule

// File: tb/tb_ipl_decoder.sv
// Self-checking bench for ipl_decoder: table of filtered-level/pending vectors
// plus hand-written acknowledge, NMI, glitch and reset sequences.
module tb_ipl_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] ipl_n = 3'b111;
    logic [2:0] imask = 3'd0;
    int         checks = 0;
    int         errors = 0;
    int         valid_cnt = 0;
    int         vc0;

    ipl_decoder_if bus ();

    ipl_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .ipl_n (ipl_n),
        .imask (imask),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.vector_valid) valid_cnt++;
    end

    typedef struct {
        logic [2:0] ipl_n;
        logic [2:0] imask;
        logic       exp_pending;
        logic [2:0] exp_level;
    } vec_t;

    vec_t tbl [8];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_accept();
        bus.iack_start = 1'b1;
        step(1);
        bus.iack_start = 1'b0;
    endtask

    initial begin
        bus.iack_start = 1'b0;
        bus.dtack_n    = 1'b1;
        bus.vpa_n      = 1'b1;
        bus.berr_n     = 1'b1;
        bus.data_in    = 8'h00;

        tbl[0] = '{3'b111, 3'd0, 1'b0, 3'd0};
        tbl[1] = '{3'b100, 3'd2, 1'b1, 3'd3};
        tbl[2] = '{3'b100, 3'd3, 1'b0, 3'd3};
        tbl[3] = '{3'b010, 3'd5, 1'b0, 3'd5};
        tbl[4] = '{3'b010, 3'd4, 1'b1, 3'd5};
        tbl[5] = '{3'b110, 3'd0, 1'b1, 3'd1};
        tbl[6] = '{3'b110, 3'd1, 1'b0, 3'd1};
        tbl[7] = '{3'b001, 3'd7, 1'b0, 3'd6};

        // Reset state
        #12;
        chk("rst_pending",  32'(bus.int_pending), 32'd0);
        chk("rst_level",    32'(bus.int_level), 32'd0);
        chk("rst_iack_req", 32'(bus.iack_req), 32'd0);
        chk("rst_iack_lvl", 32'(bus.iack_lvl), 32'd0);
        chk("rst_vector",   32'(bus.vector), 32'd0);
        chk("rst_valid",    32'(bus.vector_valid), 32'd0);
        chk("rst_spurious", 32'(bus.spurious), 32'd0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("post_rst_level",   32'(bus.int_level), 32'd0);
        chk("post_rst_pending", 32'(bus.int_pending), 32'd0);

        // Table: filtered level and mask compare
        for (int i = 0; i < 8; i++) begin
            ipl_n = tbl[i].ipl_n;
            imask = tbl[i].imask;
            step(4);
            chk($sformatf("tbl%0d_pending", i), 32'(bus.int_pending), 32'(tbl[i].exp_pending));
            chk($sformatf("tbl%0d_level", i),   32'(bus.int_level),   32'(tbl[i].exp_level));
        end

        // Latency SYNC_STAGES+1, then autovectored acknowledge at level 3
        ipl_n = 3'b111; imask = 3'd2;
        step(4);
        chk("lat_idle_pending", 32'(bus.int_pending), 32'd0);
        ipl_n = 3'b100;
        step(2);
        chk("lat_early_pending", 32'(bus.int_pending), 32'd0);
        step(1);
        chk("lat_pending", 32'(bus.int_pending), 32'd1);
        do_accept();
        chk("av_iack_req", 32'(bus.iack_req), 32'd1);
        chk("av_iack_lvl", 32'(bus.iack_lvl), 32'd3);
        chk("av_pending_ack", 32'(bus.int_pending), 32'd0);
        step(2);
        chk("av_wait_req", 32'(bus.iack_req), 32'd1);
        vc0 = valid_cnt;
        bus.vpa_n = 1'b0;
        step(1);
        bus.vpa_n = 1'b1;
        chk("av_vector", 32'(bus.vector), 32'd27);
        chk("av_spurious", 32'(bus.spurious), 32'd0);
        chk("av_valid", 32'(bus.vector_valid), 32'd1);
        chk("av_req_drop", 32'(bus.iack_req), 32'd0);
        step(1);
        chk("av_valid_once", 32'(bus.vector_valid), 32'd0);
        chk("av_valid_count", 32'(valid_cnt - vc0), 32'd1);
        chk("av_vector_hold", 32'(bus.vector), 32'd27);

        // Mask boundary, then vectored termination with an imask change mid-cycle
        ipl_n = 3'b010; imask = 3'd5;
        step(4);
        chk("vec_masked", 32'(bus.int_pending), 32'd0);
        imask = 3'd4;
        step(1);
        chk("vec_unmasked", 32'(bus.int_pending), 32'd1);
        do_accept();
        imask = 3'd7;
        step(2);
        chk("vec_req_hold", 32'(bus.iack_req), 32'd1);
        chk("vec_level_frozen", 32'(bus.int_level), 32'd5);
        bus.data_in = 8'h40;
        bus.dtack_n = 1'b0;
        step(1);
        bus.dtack_n = 1'b1;
        chk("vec_vector", 32'(bus.vector), 32'h40);
        chk("vec_spurious", 32'(bus.spurious), 32'd0);
        chk("vec_valid", 32'(bus.vector_valid), 32'd1);

        // NMI: single pend while held, re-pend after a fresh edge
        ipl_n = 3'b000; imask = 3'd7;
        step(4);
        chk("nmi_pending", 32'(bus.int_pending), 32'd1);
        chk("nmi_level", 32'(bus.int_level), 32'd7);
        do_accept();
        bus.vpa_n = 1'b0;
        step(1);
        bus.vpa_n = 1'b1;
        chk("nmi_vector", 32'(bus.vector), 32'd31);
        step(4);
        chk("nmi_no_repend", 32'(bus.int_pending), 32'd0);
        ipl_n = 3'b111;
        step(4);
        chk("nmi_drop_level", 32'(bus.int_level), 32'd0);
        ipl_n = 3'b000;
        step(4);
        chk("nmi_repend", 32'(bus.int_pending), 32'd1);
        do_accept();
        bus.berr_n = 1'b0;
        bus.vpa_n  = 1'b0;
        step(1);
        bus.berr_n = 1'b1;
        bus.vpa_n  = 1'b1;
        chk("berr_vector", 32'(bus.vector), 32'd24);
        chk("berr_spurious", 32'(bus.spurious), 32'd1);
        chk("berr_valid", 32'(bus.vector_valid), 32'd1);
        step(1);
        chk("berr_spur_hold", 32'(bus.spurious), 32'd1);
        chk("berr_no_repend", 32'(bus.int_pending), 32'd0);

        // One-cycle glitch is filtered out
        ipl_n = 3'b111; imask = 3'd0;
        step(4);
        ipl_n = 3'b010;
        step(1);
        ipl_n = 3'b111;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk($sformatf("glitch_level%0d", i), 32'(bus.int_level), 32'd0);
            chk($sformatf("glitch_pend%0d", i), 32'(bus.int_pending), 32'd0);
        end

        // Level-7 edge during ACK is remembered for the return to IDLE
        ipl_n = 3'b100; imask = 3'd2;
        step(4);
        do_accept();
        ipl_n = 3'b000;
        step(4);
        chk("ackedge_req", 32'(bus.iack_req), 32'd1);
        chk("ackedge_level", 32'(bus.int_level), 32'd3);
        bus.vpa_n = 1'b0;
        step(1);
        bus.vpa_n = 1'b1;
        chk("ackedge_vector", 32'(bus.vector), 32'd27);
        step(1);
        chk("ackedge_pending", 32'(bus.int_pending), 32'd1);
        chk("ackedge_newlevel", 32'(bus.int_level), 32'd7);

        // Asynchronous reset in the middle of an acknowledge cycle
        do_accept();
        chk("rstack_req_before", 32'(bus.iack_req), 32'd1);
        vc0 = valid_cnt;
        #2 rst = 1'b1;
        #1;
        chk("rstack_req_async", 32'(bus.iack_req), 32'd0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("rstack_no_valid", 32'(valid_cnt - vc0), 32'd0);
        chk("rstack_vector", 32'(bus.vector), 32'd0);
        chk("rstack_iack_lvl", 32'(bus.iack_lvl), 32'd0);
        step(2);
        chk("rstack_nmi_repend", 32'(bus.int_pending), 32'd1);

`ifdef IACK_TIMEOUT_EN
        do_accept();
        step(63);
        chk("to_still_waiting", 32'(bus.iack_req), 32'd1);
        step(1);
        chk("to_valid", 32'(bus.vector_valid), 32'd1);
        chk("to_vector", 32'(bus.vector), 32'd24);
        chk("to_spurious", 32'(bus.spurious), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
